// File: rtl/fpu_sequencer.sv
// Execute-stage sequencer for the multi-cycle FPU: launches the core, counts the
// operation latency, drives the F/D stall (FPUOkE) and keeps a saturating stall count.
module fpu_sequencer #(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 4,
  parameter int unsigned LAT_DIV  = 16,
  parameter int unsigned LAT_SQRT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FPUOpE,
  input  logic [2:0]  FPUCtrlE,
  input  logic        KillE,
  output logic        FPUStart,
  output logic        FPUAbort,
  output logic        FPUOkE,
  output logic        FPUResultValid,
  output logic        FPUBusy,
  output logic [31:0] StallCount
);

  typedef enum logic {Idle, Busy} stateT;

  stateT       stateQ, stateD;
  logic [4:0]  cntQ, cntD;
  logic [5:0]  lat;
  logic        multiOp;
  logic        start, abort, ok, valid;
  logic [31:0] stallCnt;

  always_comb begin
    case (FPUCtrlE)
      3'b000, 3'b001: lat = 6'(LAT_ADD);
      3'b010:         lat = 6'(LAT_MUL);
      3'b011:         lat = 6'(LAT_DIV);
      3'b100:         lat = 6'(LAT_SQRT);
      default:        lat = 6'd1;
    endcase
  end

  assign multiOp = FPUOpE && (lat > 6'd1);

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    start  = 1'b0;
    abort  = 1'b0;
    ok     = 1'b1;
    valid  = 1'b0;
    case (stateQ)
      Idle: begin
        if (!KillE) begin
          if (multiOp) begin
            start  = 1'b1;
            ok     = 1'b0;
            stateD = Busy;
            cntD   = 5'(lat - 6'd2);
          end else begin
            valid = FPUOpE;
          end
        end
      end
      Busy: begin
        if (KillE) begin
          abort  = 1'b1;
          stateD = Idle;
          cntD   = 5'd0;
        end else if (cntQ != 5'd0) begin
          ok   = 1'b0;
          cntD = cntQ - 5'd1;
        end else begin
          valid  = 1'b1;
          stateD = Idle;
        end
      end
      default: begin
        stateD = Idle;
        cntD   = 5'd0;
      end
    endcase
  end

  // Combinational outputs are masked so they hold their reset values while reset is low.
  assign FPUStart       = reset & start;
  assign FPUAbort       = reset & abort;
  assign FPUResultValid = reset & valid;
  assign FPUOkE         = ~reset | ok;
  assign FPUBusy        = (stateQ == Busy);
  assign StallCount     = stallCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= Idle;
      cntQ   <= 5'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= 32'd0;
    end else if (!FPUOkE && (stallCnt != 32'hFFFF_FFFF)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer: directed per-cycle vectors are queued as they are
// driven; a negedge monitor pops and compares them against the DUT outputs.
module tb_fpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        opE, killE, op2, kill2;
  logic [2:0]  ctrlE, ctrl2;
  logic        start1, abort1, ok1, valid1, busy1;
  logic        start2, abort2, ok2, valid2, busy2;
  logic [31:0] stall1, stall2;

  typedef struct packed {
    logic        start;
    logic        abort;
    logic        ok;
    logic        valid;
    logic        busy;
    logic [31:0] stall;
  } expT;

  expT         q1[$];
  expT         q2[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] expStall = 32'd0;

  always #5 clk = ~clk;

  fpu_sequencer dut1 (
    .clk           (clk),
    .reset         (reset),
    .FPUOpE        (opE),
    .FPUCtrlE      (ctrlE),
    .KillE         (killE),
    .FPUStart      (start1),
    .FPUAbort      (abort1),
    .FPUOkE        (ok1),
    .FPUResultValid(valid1),
    .FPUBusy       (busy1),
    .StallCount    (stall1)
  );

  // Second instance with single-cycle add/sub.
  fpu_sequencer #(.LAT_ADD(1)) dut2 (
    .clk           (clk),
    .reset         (reset),
    .FPUOpE        (op2),
    .FPUCtrlE      (ctrl2),
    .KillE         (kill2),
    .FPUStart      (start2),
    .FPUAbort      (abort2),
    .FPUOkE        (ok2),
    .FPUResultValid(valid2),
    .FPUBusy       (busy2),
    .StallCount    (stall2)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Monitor: one queued entry per driven cycle, compared mid-cycle.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        cmp("dut1.FPUStart", 32'(start1), 32'(e.start));
        cmp("dut1.FPUAbort", 32'(abort1), 32'(e.abort));
        cmp("dut1.FPUOkE", 32'(ok1), 32'(e.ok));
        cmp("dut1.FPUResultValid", 32'(valid1), 32'(e.valid));
        cmp("dut1.FPUBusy", 32'(busy1), 32'(e.busy));
        cmp("dut1.StallCount", stall1, e.stall);
      end
      if (q2.size() != 0) begin
        e = q2.pop_front();
        cmp("dut2.FPUStart", 32'(start2), 32'(e.start));
        cmp("dut2.FPUOkE", 32'(ok2), 32'(e.ok));
        cmp("dut2.FPUResultValid", 32'(valid2), 32'(e.valid));
        cmp("dut2.FPUBusy", 32'(busy2), 32'(e.busy));
        cmp("dut2.StallCount", stall2, e.stall);
      end
    end
  end

  // Drive one cycle of dut1 with its hand-derived expected outputs, then advance.
  task automatic step(input logic rstN, input logic op, input logic [2:0] ctrl,
                      input logic kill, input logic s, input logic a, input logic o,
                      input logic v, input logic b);
    expT e;
    reset = rstN;
    opE   = op;
    ctrlE = ctrl;
    killE = kill;
    op2   = 1'b0;
    ctrl2 = 3'b000;
    kill2 = 1'b0;
    e.start = s;
    e.abort = a;
    e.ok    = o;
    e.valid = v;
    e.busy  = b;
    e.stall = expStall;
    q1.push_back(e);
    if (!o && (expStall != 32'hFFFF_FFFF)) expStall = expStall + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic op, input logic [2:0] ctrl, input logic s, input logic o,
                       input logic v);
    expT e;
    opE   = 1'b0;
    ctrlE = 3'b000;
    killE = 1'b0;
    op2   = op;
    ctrl2 = ctrl;
    kill2 = 1'b0;
    e.start = s;
    e.abort = 1'b0;
    e.ok    = o;
    e.valid = v;
    e.busy  = 1'b0;
    e.stall = 32'd0;
    q2.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    opE   = 1'b1;
    ctrlE = 3'b011;
    killE = 1'b0;
    op2   = 1'b0;
    ctrl2 = 3'b000;
    kill2 = 1'b0;
    @(posedge clk);
    #1;

    // Held in reset with a div pending: outputs stay at reset values.
    step(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Release: div launches (16 cycles); ctrl flips to add while busy and must be ignored.
    step(1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    // Add immediately follows (3 cycles).
    step(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // StallCount 17

    // Mul: 4 cycles.
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // StallCount 20

    // Sqrt killed in cycle 5.
    step(1'b1, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);  // StallCount 25

    // Kill in IDLE with a mul presented: no launch.
    step(1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Single-cycle op (110) and a non-FPU cycle with the same ctrl.
    step(1'b1, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // LAT_ADD = 1 instance: add and sub are single-cycle.
    step2(1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
    step2(1'b1, 3'b001, 1'b0, 1'b1, 1'b1);
    step2(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);

    // Saturation: preload near the top, then a 4-cycle mul.
    force dut1.stallCnt = 32'hFFFF_FFFE;
    #1;
    release dut1.stallCnt;
    expStall = 32'hFFFF_FFFE;
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if ((q1.size() + q2.size()) != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0 entries left", q1.size() + q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
